// File: rtl/baud_prescaler_pkg.sv
// Shared constants for the UART baud-rate prescaler.
// Optional feature macro: BAUD_PRESCALER_FRAC_EN (fractional divisor).
package baud_prescaler_pkg;

    localparam int CNT_W_DEF      = 16;
    localparam int FRAC_W_DEF     = 4;
    localparam int OVERSAMPLE_DEF = 16;

    function automatic int phase_w(input int os);
        return (os < 2) ? 1 : $clog2(os);
    endfunction

    localparam int PHASE_W = phase_w(OVERSAMPLE_DEF);

    localparam logic [CNT_W_DEF-1:0] DIV_115200 = 16'd28;
    localparam logic [CNT_W_DEF-1:0] DIV_57600  = 16'd56;
    localparam logic [CNT_W_DEF-1:0] DIV_38400  = 16'd84;
    localparam logic [CNT_W_DEF-1:0] DIV_19200  = 16'd168;

endpackage

// File: rtl/baud_prescaler_if.sv
// Rate-configuration handshake between a host and the baud prescaler.
// Optional feature macro: BAUD_PRESCALER_FRAC_EN (uses cfg_frac).
interface baud_prescaler_if #(
    parameter int CNT_W  = 16,
    parameter int FRAC_W = 4
);

    logic              cfg_valid;
    logic              cfg_ready;
    logic [CNT_W-1:0]  cfg_div;
    logic [FRAC_W-1:0] cfg_frac;

    modport master (
        output cfg_valid,
        output cfg_div,
        output cfg_frac,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        input  cfg_frac,
        output cfg_ready
    );

endinterface

// File: rtl/baud_prescaler_div_core.sv
// Cycle counter with optional fractional accumulator; emits a wrap strobe.
// Optional feature macro: BAUD_PRESCALER_FRAC_EN.
module baud_div_core #(
    parameter int CNT_W  = 16,
    parameter int FRAC_W = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              en,
    input  logic              clr,
    input  logic [CNT_W-1:0]  div,
    input  logic [FRAC_W-1:0] frac,
    output logic              wrap
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   base;
    logic [CNT_W:0]   last;
    logic             ext;

    // One extra bit so a maximal divisor plus ext cannot overflow.
    always_comb begin
        base = {1'b0, div};
        if (div == '0) base = (CNT_W+1)'(1);
        last = base + {{CNT_W{1'b0}}, ext} - (CNT_W+1)'(1);
    end

    assign wrap = en && ({1'b0, cnt} == last);

    always_ff @(posedge clock) begin
        if (!reset_n || clr) begin
            cnt <= '0;
        end else if (wrap) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + (CNT_W)'(1);
        end
    end

`ifdef BAUD_PRESCALER_FRAC_EN
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W:0]   sum;

    assign sum = {1'b0, acc} + {1'b0, frac};

    // Carry out stretches the following period by one cycle.
    always_ff @(posedge clock) begin
        if (!reset_n || clr) begin
            acc <= '0;
            ext <= 1'b0;
        end else if (wrap) begin
            acc <= sum[FRAC_W-1:0];
            ext <= sum[FRAC_W];
        end
    end
`else
    logic frac_unused;

    assign frac_unused = ^frac;
    assign ext         = 1'b0;
`endif

endmodule

// File: rtl/baud_prescaler.sv
// Runtime-programmable UART baud generator: sample tick and bit tick.
// Optional feature macro: BAUD_PRESCALER_FRAC_EN (fractional divisor).
module baud_prescaler
    import baud_prescaler_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int OVERSAMPLE = 16,
    parameter int FRAC_W     = 4,
    parameter int RESET_DIV  = 28
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             enable,
    input  logic                             restart,
    baud_prescaler_if.slave                  cfg,
    output logic                             sample_tick,
    output logic                             bit_tick,
    output logic [phase_w(OVERSAMPLE)-1:0]   phase
);

    localparam int            PW      = phase_w(OVERSAMPLE);
    localparam logic [PW-1:0] PH_LAST = (PW)'(OVERSAMPLE - 1);

    logic [CNT_W-1:0]  div_q;
    logic [FRAC_W-1:0] frac_q;
    logic [CNT_W-1:0]  sh_div;
    logic [FRAC_W-1:0] sh_frac;
    logic              sh_full;
    logic              run;
    logic              wrap;
    logic              boundary;
    logic              apply;
    logic              accept;

    assign run      = enable && !restart;
    assign boundary = wrap && (phase == PH_LAST);
    assign apply    = sh_full && (restart || !enable || boundary);
    assign accept   = cfg.cfg_valid && !sh_full;

    assign cfg.cfg_ready = !sh_full;

    baud_div_core #(
        .CNT_W  (CNT_W),
        .FRAC_W (FRAC_W)
    ) u_core (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (run),
        .clr     (apply || restart),
        .div     (div_q),
        .frac    (frac_q),
        .wrap    (wrap)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sample_tick <= 1'b0;
            bit_tick    <= 1'b0;
            phase       <= '0;
        end else begin
            sample_tick <= wrap;
            bit_tick    <= boundary;
            unique case (1'b1)
                restart: phase <= '0;
                wrap:    phase <= (phase == PH_LAST) ? '0 : phase + (PW)'(1);
                default: phase <= phase;
            endcase
        end
    end

    // Shadow is only refilled once empty, so accept and apply never coincide.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            div_q   <= (CNT_W)'(RESET_DIV);
            frac_q  <= '0;
            sh_div  <= '0;
            sh_frac <= '0;
            sh_full <= 1'b0;
        end else if (accept) begin
            sh_div  <= cfg.cfg_div;
            sh_frac <= cfg.cfg_frac;
            sh_full <= 1'b1;
        end else if (apply) begin
            div_q   <= sh_div;
            frac_q  <= sh_frac;
            sh_full <= 1'b0;
        end
    end

endmodule

// File: tb/tb_baud_prescaler.sv
// Directed bench for baud_prescaler: tick spacing, config apply, restart, reset.
// Fractional expectations follow BAUD_PRESCALER_FRAC_EN.
module tb_baud_prescaler;

    localparam int LIMIT = 2000;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable  = 1'b0;
    logic       restart = 1'b0;
    logic       sample_tick;
    logic       bit_tick;
    logic [3:0] phase;

    int nvec = 0;
    int nerr = 0;

    baud_prescaler_if #(.CNT_W(16), .FRAC_W(4)) cfg ();

    baud_prescaler #(
        .CNT_W      (16),
        .OVERSAMPLE (16),
        .FRAC_W     (4),
        .RESET_DIV  (28)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .restart     (restart),
        .cfg         (cfg),
        .sample_tick (sample_tick),
        .bit_tick    (bit_tick),
        .phase       (phase)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input longint obs, input longint exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (!sample_tick && n < LIMIT);
    endtask

    task automatic wait_bit(output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (!bit_tick && n < LIMIT);
    endtask

    task automatic cfg_write(input logic [15:0] d, input logic [3:0] f);
        logic ok;
        int   n;
        n = 0;
        cfg.cfg_valid = 1'b1;
        cfg.cfg_div   = d;
        cfg.cfg_frac  = f;
        do begin
            ok = cfg.cfg_ready;
            step(1);
            n++;
        end while (!ok && n < LIMIT);
        cfg.cfg_valid = 1'b0;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        step(1);
        restart = 1'b0;
    endtask

    initial begin
        int n;
        int sum;
        int iv1;
        int iv2;
        int seen;
        logic [3:0] ph;

        cfg.cfg_valid = 1'b0;
        cfg.cfg_div   = '0;
        cfg.cfg_frac  = '0;

        // reset state
        step(2);
        check("rst_sample", sample_tick, 0);
        check("rst_bit", bit_tick, 0);
        check("rst_phase", phase, 0);
        check("rst_ready", cfg.cfg_ready, 1);

        // default 28-cycle rate
        reset_n = 1'b1;
        enable  = 1'b1;
        wait_tick(n);
        check("t1_first", n, 28);
        check("t1_phase1", phase, 1);
        wait_tick(n);
        check("t1_period", n, 28);
        wait_bit(n);
        check("t1_bit_first", n, 392);
        check("t1_bit_samp", sample_tick, 1);
        check("t1_bit_phase", phase, 0);
        wait_bit(n);
        check("t1_bit_period", n, 448);
        check("t1_ready", cfg.cfg_ready, 1);

        // div=0 applied while disabled
        enable = 1'b0;
        cfg_write(16'd0, 4'd0);
        check("t2_ready_lo", cfg.cfg_ready, 0);
        step(1);
        check("t2_ready_hi", cfg.cfg_ready, 1);
        pulse_restart();
        check("t2_phase0", phase, 0);
        enable = 1'b1;
        wait_bit(n);
        check("t2_div0_bit", n, 16);
        wait_tick(n);
        check("t2_div0_tick", n, 1);

        // div=1 applied by restart
        cfg_write(16'd1, 4'd0);
        check("t2_div1_ready_lo", cfg.cfg_ready, 0);
        pulse_restart();
        check("t2_div1_ready_hi", cfg.cfg_ready, 1);
        check("t2_div1_phase0", phase, 0);
        wait_tick(n);
        check("t2_div1_tick", n, 1);
        wait_bit(n);
        check("t2_div1_bit", n, 15);

        // div=4 frac=8
        cfg_write(16'd4, 4'd8);
        pulse_restart();
        wait_tick(n);
        check("t3_first", n, 4);
        wait_tick(iv1);
        wait_tick(iv2);
        sum = iv1 + iv2;
        for (int i = 0; i < 30; i++) begin
            wait_tick(n);
            sum += n;
        end
`ifdef BAUD_PRESCALER_FRAC_EN
        check("t3_p2", iv1, 4);
        check("t3_p3", iv2, 5);
        check("t3_32ticks", sum, 144);
`else
        check("t3_p2", iv1, 4);
        check("t3_p3", iv2, 4);
        check("t3_32ticks", sum, 128);
`endif

        // rate change mid-bit waits for the bit boundary
        cfg_write(16'd28, 4'd0);
        pulse_restart();
        wait_tick(n);
        check("t4_first", n, 28);
        step(56);
        check("t4_phase3", phase, 3);
        cfg_write(16'd56, 4'd0);
        check("t4_ready_lo", cfg.cfg_ready, 0);
        wait_tick(n);
        check("t4_old_rate", n, 27);
        check("t4_ready_still_lo", cfg.cfg_ready, 0);
        wait_bit(n);
        check("t4_bit", n, 336);
        check("t4_ready_hi", cfg.cfg_ready, 1);
        wait_tick(n);
        check("t4_new_rate", n, 56);

        // restart at phase 7 with pending config
        seen = 0;
        while (phase != 4'd7 && seen < 20) begin
            wait_tick(n);
            seen++;
        end
        check("t5_phase7", phase, 7);
        cfg_write(16'd28, 4'd0);
        pulse_restart();
        check("t5_phase0", phase, 0);
        check("t5_ready", cfg.cfg_ready, 1);
        check("t5_no_tick", sample_tick, 0);
        wait_tick(n);
        check("t5_after", n, 28);

        // freeze while disabled
        step(10);
        ph     = phase;
        enable = 1'b0;
        seen   = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (sample_tick || bit_tick) seen++;
        end
        check("t6_no_ticks", seen, 0);
        check("t6_phase_hold", phase, ph);
        enable = 1'b1;
        wait_tick(n);
        check("t6_resume", n, 18);

        // reset mid-operation drops pending config
        cfg_write(16'd56, 4'd0);
        step(5);
        reset_n = 1'b0;
        step(1);
        check("t6_rst_sample", sample_tick, 0);
        check("t6_rst_bit", bit_tick, 0);
        check("t6_rst_phase", phase, 0);
        check("t6_rst_ready", cfg.cfg_ready, 1);
        reset_n = 1'b1;
        wait_tick(n);
        check("t6_rst_div", n, 28);
        wait_tick(n);
        check("t6_rst_period", n, 28);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
